fan_mode_ctrl: RTL
==================

FAN_MODE_CTRL -- requirements
Module: fan_mode_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, is the number of consecutive stable synchronized samples needed to accept a button level change (legal range 2..255).
REQ-002 clk  input  1  single system clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 elec  input  1  mains-present flag, synchronous to clk (1 = power present).
REQ-005 btn_up  input  1  raw asynchronous push button, active-high (step speed up).
REQ-006 btn_dn  input  1  raw asynchronous push button, active-high (step speed down).
REQ-007 btn_off  input  1  raw asynchronous push button, active-high (force off).
REQ-008 mod  output  3  registered mode code for the downstream fan speed stage: 0=off, 1, 2, 3; values 4..7 never driven.
REQ-009 fan_on  output  1  registered; 1 when mod != 0.

Function
REQ-010 Each button shall pass through a 2-flop synchronizer and then a debouncer whose level toggles only after the synchronized value differs from it for DEBOUNCE_CYCLES consecutive cycles; any glitch restarts the count.
REQ-011 Each debouncer shall emit a one-cycle press pulse on a 0->1 transition of its debounced level; releases and held levels produce no further pulses.
REQ-012 Mode FSM states: OFF, M1, M2, M3; mod = 0, 1, 2, 3 respectively; mod updates on the edge after the press pulse.
REQ-013 Latency: raw press held stable, first sampled high at edge N, shall change mod at edge N+DEBOUNCE_CYCLES+3.
REQ-014 up pulse: OFF->M1->M2->M3; M3 saturates (no wrap to OFF).
REQ-015 dn pulse: M3->M2->M1->OFF; OFF saturates (no wrap to M3).
REQ-016 off pulse: any state -> OFF; last_mode memory is cleared to OFF.
REQ-017 Simultaneous pulses in one cycle: off wins over all; up and dn together without off shall be ignored (state unchanged).
REQ-018 While elec=0: mod forced to 0 and fan_on to 0 on the next edge; press pulses are discarded; debouncers keep running.
REQ-019 On the elec 1->0 edge the current state shall be saved to last_mode; on the elec 0->1 edge the FSM shall resume last_mode, with mod valid on the following edge.
REQ-020 A press pulse coincident with the elec 0->1 edge shall be discarded; the restore takes priority.
REQ-021 fan_on shall always equal (mod != 0) in the same cycle.

Reset
REQ-022 rst asserted shall immediately force: mod=0, fan_on=0, FSM=OFF, last_mode=OFF, all synchronizer flops, debounced levels and counters = 0.
REQ-023 Reset mid-debounce or mid-press shall discard the pending press; a button still held at deassertion shall produce one pulse after a full debounce period.
REQ-024 The first rising edge after rst deasserts shall be the first active edge; no pulse shall be generated on that edge.

Structure
REQ-025 Shared package fan_pkg shall hold the mode encodings (MODE_OFF=0, MODE_1=1, MODE_2=2, MODE_3=3), the 3-bit mode width, and the default DEBOUNCE_CYCLES.
REQ-026 One sub-module, btn_debounce (synchronizer + debounce counter + press pulse), shall be instantiated three times; the FSM and the power-loss memory shall reside in fan_mode_ctrl.

Verification
REQ-027 elec=1, DEBOUNCE_CYCLES=4, btn_up held 10 cycles from edge N -> mod 0->1 exactly at edge N+7; 3 further presses -> mod 2, 3, 3.
REQ-028 btn_up pulsed high for 2 cycles (shorter than the debounce period) -> no mod change; a bounce pattern 1,0,1,1,1,1 -> exactly one step.
REQ-029 Mode 3, btn_up and btn_dn pressed together -> mod stays 3; btn_off with btn_up together -> mod 0.
REQ-030 Mode 2, elec 1->0 -> mod=0 and fan_on=0 next edge; presses during the outage are ignored; elec 0->1 -> mod=2 next edge.
REQ-031 Mode 2, btn_off pressed, then elec cycles 1->0->1 -> mod stays 0 after the restore.
REQ-032 rst asserted mid-debounce at mode 3 -> mod=0 asynchronously; btn still held after release -> mod=1 after DEBOUNCE_CYCLES+3 edges.

Source files
------------

// File: rtl/fan_pkg.sv
// Shared definitions for the fan mode controller: mode encodings,
// mode width, debounce defaults and mode stepping helpers.
package fan_pkg;

    localparam int unsigned MODE_W           = 3;
    localparam int unsigned DEBOUNCE_DEFAULT = 4;
    localparam int unsigned DEB_CNT_W        = 8;

    typedef enum logic [MODE_W-1:0] {
        MODE_OFF = 3'd0,
        MODE_1   = 3'd1,
        MODE_2   = 3'd2,
        MODE_3   = 3'd3
    } mode_e;

    // One step faster, saturating at MODE_3.
    function automatic mode_e mode_step_up(input mode_e m);
        mode_e r;
        case (m)
            MODE_OFF: r = MODE_1;
            MODE_1:   r = MODE_2;
            default:  r = MODE_3;
        endcase
        return r;
    endfunction

    // One step slower, saturating at MODE_OFF.
    function automatic mode_e mode_step_dn(input mode_e m);
        mode_e r;
        case (m)
            MODE_3:  r = MODE_2;
            MODE_2:  r = MODE_1;
            default: r = MODE_OFF;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioning: 2-flop synchronizer, debounce counter and a
// registered one-cycle press pulse on each accepted 0->1 level change.
module btn_debounce
    import fan_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_press
);

    localparam logic [DEB_CNT_W-1:0] CNT_LAST = DEB_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic                 r_sync1;
    logic                 r_sync2;
    logic                 r_level;
    logic                 r_level_d;
    logic                 r_press;
    logic [DEB_CNT_W-1:0] r_cnt;
    logic                 w_differ;
    logic                 w_cnt_done;

    assign w_differ   = r_sync2 ^ r_level;
    assign w_cnt_done = (r_cnt == CNT_LAST);

    // Bring the raw asynchronous button into the clock domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
        end
    end

    // Accept a new level only after it has been stable for the full period;
    // any sample matching the current level restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else if (!w_differ) begin
            r_cnt <= '0;
        end else if (w_cnt_done) begin
            r_level <= r_sync2;
            r_cnt   <= '0;
        end else begin
            r_cnt <= r_cnt + DEB_CNT_W'(1);
        end
    end

    // Registered rising-edge detect on the debounced level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_level_d <= 1'b0;
            r_press   <= 1'b0;
        end else begin
            r_level_d <= r_level;
            r_press   <= r_level & ~r_level_d;
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/fan_mode_ctrl.sv
// Fan mode controller: three debounced buttons step a four-state speed
// FSM; mains loss forces the fan off and remembers the mode for restore.
module fan_mode_ctrl
    import fan_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              elec,
    input  logic              btn_up,
    input  logic              btn_dn,
    input  logic              btn_off,
    output logic [MODE_W-1:0] mod,
    output logic              fan_on
);

    logic              w_up;
    logic              w_dn;
    logic              w_off;
    logic              w_elec_rise;
    logic              w_elec_fall;
    logic              w_run;
    mode_e             r_state;
    mode_e             w_state_nxt;
    mode_e             r_last;
    mode_e             w_last_nxt;
    logic              r_elec_d;
    logic [MODE_W-1:0] r_mod;
    logic [MODE_W-1:0] w_mod_nxt;
    logic              r_fan_on;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_up (
        .clk     (clk),
        .rst     (rst),
        .i_btn   (btn_up),
        .o_press (w_up)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_dn (
        .clk     (clk),
        .rst     (rst),
        .i_btn   (btn_dn),
        .o_press (w_dn)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_off (
        .clk     (clk),
        .rst     (rst),
        .i_btn   (btn_off),
        .o_press (w_off)
    );

    assign w_elec_rise = elec & ~r_elec_d;
    assign w_elec_fall = ~elec & r_elec_d;
    assign w_run       = elec & r_elec_d;

    // Next mode and power-loss memory; restore beats any coincident press,
    // and presses are only honoured while power has been present for a cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        w_mod_nxt   = '0;
        if (w_elec_rise) begin
            w_state_nxt = r_last;
        end else if (w_elec_fall) begin
            w_last_nxt = r_state;
        end else if (w_run) begin
            if (w_off) begin
                w_state_nxt = MODE_OFF;
                w_last_nxt  = MODE_OFF;
            end else if (w_up && !w_dn) begin
                w_state_nxt = mode_step_up(r_state);
            end else if (w_dn && !w_up) begin
                w_state_nxt = mode_step_dn(r_state);
            end
        end
        if (elec) begin
            w_mod_nxt = w_state_nxt;
        end
    end

    // FSM state, power-loss memory and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= MODE_OFF;
            r_last   <= MODE_OFF;
            r_elec_d <= 1'b0;
            r_mod    <= '0;
            r_fan_on <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_last   <= w_last_nxt;
            r_elec_d <= elec;
            r_mod    <= w_mod_nxt;
            r_fan_on <= (w_mod_nxt != '0);
        end
    end

    assign mod    = r_mod;
    assign fan_on = r_fan_on;

endmodule
